// File: rtl/ddr_bank_initiator.sv
// ddr_bank_initiator: issues PR/ACT/RD/WR/REF commands to one emulated DRAM bank.
// Single-beat read/write requests arrive on a valid/ready port. The bank uses an
// open-page policy, and refresh is inserted periodically.
module ddr_bank_initiator #(
   parameter int WIDTH = 4,
   parameter int ROWS  = 131072,
   parameter int COLS  = 1024,
   parameter int TRP   = 3,
   parameter int TRCD  = 3,
   parameter int TCL   = 2,
   parameter int TWR   = 2,
   parameter int TRFC  = 8,
   parameter int TREFI = 200
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [$clog2(ROWS)-1:0]  req_row,
   input  logic [$clog2(COLS)-1:0]  req_col,
   input  logic [WIDTH-1:0]         req_wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     rdata_valid,
   output logic                     ACT,
   output logic                     PR,
   output logic                     RD,
   output logic                     WR,
   output logic                     REF,
   output logic [$clog2(ROWS)-1:0]  row,
   output logic [$clog2(COLS)-1:0]  column,
   inout  wire  [WIDTH-1:0]         dq,
   inout  wire                      dqs_t,
   inout  wire                      dqs_c
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   // A WAIT of N cycles is loaded with N-1 because it exits on zero.
   // A command with spacing d therefore needs d-1 WAIT cycles, which means a load of d-2.
   localparam logic [7:0] TRP_LD   = 8'(TRP - 2);
   localparam logic [7:0] TRCD_LD  = 8'(TRCD - 2);
   localparam logic [7:0] TWR_LD   = 8'(TWR - 2);
   localparam logic [7:0] TRFC_LD  = 8'(TRFC - 2);
   localparam logic [7:0] TCL_LD   = 8'(TCL - 1);
   localparam logic [7:0] TREFI_LAST = 8'(TREFI - 1);

   typedef enum logic [2:0] {IDLE, PRE, ACT_S, WR_S, RD_S, WAIT, REF_S} state_t;

   state_t          state, next_state;
   state_t          wait_next, next_wait;
   logic [7:0]      cnt, next_cnt;
   logic            accept;

   logic            lat_we;
   logic [RW-1:0]   lat_row;
   logic [CW-1:0]   lat_col;
   logic [WIDTH-1:0] lat_wdata;
   logic            open_valid;
   logic [RW-1:0]   open_row;
   logic [7:0]      ref_cnt;
   logic            ref_pending;
   logic            ref_wrap;
   logic            rd_last;

   assign ref_wrap  = (ref_cnt == TREFI_LAST);
   assign rd_last   = (state == RD_S) && (cnt == 8'd0);
   assign req_ready = (state == IDLE) && !ref_pending;

   assign ACT = (state == ACT_S);
   assign PR  = (state == PRE);
   assign RD  = (state == RD_S);
   assign WR  = (state == WR_S);
   assign REF = (state == REF_S);

   assign row    = (state == IDLE) ? '0 : lat_row;
   assign column = (state == IDLE) ? '0 : lat_col;

   assign dq    = (state == WR_S) ? lat_wdata : {WIDTH{1'bz}};
   assign dqs_t = (state == WR_S) ? 1'b1 : 1'bz;
   assign dqs_c = (state == WR_S) ? 1'b0 : 1'bz;

   // State register, the WAIT return target and the shared wait/read counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         wait_next <= IDLE;
         cnt       <= 8'd0;
      end else begin
         state     <= next_state;
         wait_next <= next_wait;
         cnt       <= next_cnt;
      end
   end

   // Next-state logic. Refresh beats new requests, and each command waits out its spacing in WAIT.
   always_comb begin
      next_state = state;
      next_wait  = wait_next;
      next_cnt   = cnt;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (ref_pending) begin
               if (open_valid) begin
                  next_state = PRE;
                  next_wait  = REF_S;
               end else begin
                  next_state = REF_S;
               end
            end else if (req_valid) begin
               accept = 1'b1;
               if (open_valid && open_row == req_row) begin
                  next_state = req_we ? WR_S : RD_S;
               end else if (!open_valid) begin
                  next_state = ACT_S;
               end else begin
                  next_state = PRE;
                  next_wait  = ACT_S;
               end
            end
         end
         PRE: begin
            if (TRP == 1) begin
               next_state = wait_next;
            end else begin
               next_state = WAIT;
               next_cnt   = TRP_LD;
            end
         end
         ACT_S: begin
            if (TRCD == 1) begin
               next_state = lat_we ? WR_S : RD_S;
            end else begin
               next_state = WAIT;
               next_wait  = lat_we ? WR_S : RD_S;
               next_cnt   = TRCD_LD;
            end
         end
         WR_S: begin
            if (TWR == 1) begin
               next_state = IDLE;
            end else begin
               next_state = WAIT;
               next_wait  = IDLE;
               next_cnt   = TWR_LD;
            end
         end
         RD_S: begin
            if (cnt == 8'd0) begin
               next_state = IDLE;
            end else begin
               next_cnt = cnt - 8'd1;
            end
         end
         REF_S: begin
            if (TRFC == 1) begin
               next_state = IDLE;
            end else begin
               next_state = WAIT;
               next_wait  = IDLE;
               next_cnt   = TRFC_LD;
            end
         end
         WAIT: begin
            if (cnt == 8'd0) begin
               next_state = wait_next;
            end else begin
               next_cnt = cnt - 8'd1;
            end
         end
         default: next_state = IDLE;
      endcase
      if (next_state == RD_S && state != RD_S) begin
         next_cnt = TCL_LD;
      end
   end

   // Request latch, open-row tracking, refresh scheduling and read-data capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_we      <= 1'b0;
         lat_row     <= '0;
         lat_col     <= '0;
         lat_wdata   <= '0;
         open_valid  <= 1'b0;
         open_row    <= '0;
         ref_cnt     <= 8'd0;
         ref_pending <= 1'b0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
      end else begin
         if (accept) begin
            lat_we    <= req_we;
            lat_row   <= req_row;
            lat_col   <= req_col;
            lat_wdata <= req_wdata;
         end
         if (state == PRE) begin
            open_valid <= 1'b0;
         end
         if (state == ACT_S) begin
            open_valid <= 1'b1;
            open_row   <= lat_row;
         end
         if (state == REF_S) begin
            ref_pending <= 1'b0;
         end
         if (ref_wrap) begin
            ref_pending <= 1'b1;
         end
         ref_cnt     <= ref_wrap ? 8'd0 : ref_cnt + 8'd1;
         rdata_valid <= rd_last;
         if (rd_last) begin
            rdata <= dq;
         end
      end
   end

endmodule

// File: tb/tb_ddr_bank_initiator.sv
// tb_ddr_bank_initiator: checks ddr_bank_initiator with a table of hand-derived vectors,
// an asynchronous-reset sequence and randomized traffic. Every cycle is compared against a
// timestamp-scheduling reference model, and a simple bank model sits on dq.
module tb_ddr_bank_initiator;

   localparam int TRP = 3, TRCD = 3, TCL = 2, TWR = 2, TRFC = 8, TREFI = 200;

   localparam logic [5:0] V_ACT = 6'b100000;
   localparam logic [5:0] V_PR  = 6'b010000;
   localparam logic [5:0] V_RD  = 6'b001000;
   localparam logic [5:0] V_WR  = 6'b000100;
   localparam logic [5:0] V_REF = 6'b000010;
   localparam logic [5:0] V_RV  = 6'b000001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [16:0] req_row = '0;
   logic [9:0]  req_col = '0;
   logic [3:0]  req_wdata = '0;
   logic [3:0]  rdata;
   logic        rdata_valid;
   logic        act_o, pr_o, rd_o, wr_o, ref_o;
   logic [16:0] row;
   logic [9:0]  column;
   wire  [3:0]  dq;
   wire         dqs_t, dqs_c;

   logic        bank_en = 1'b0;
   logic [3:0]  bank_val = '0;
   logic [3:0]  bank_mem [int];

   assign dq = bank_en ? bank_val : 4'bzzzz;

   ddr_bank_initiator dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
      .rdata(rdata), .rdata_valid(rdata_valid),
      .ACT(act_o), .PR(pr_o), .RD(rd_o), .WR(wr_o), .REF(ref_o),
      .row(row), .column(column),
      .dq(dq), .dqs_t(dqs_t), .dqs_c(dqs_c)
   );

   always #5 clk = ~clk;

   function automatic int key(input logic [16:0] r, input logic [9:0] c);
      return int'({5'b0, r, c});
   endfunction

   // Bank emulation: stores data on WR and drives the stored word during RD cycles.
   always @(negedge clk) begin
      if (wr_o) bank_mem[key(row, column)] = dq;
      bank_en = rd_o;
      if (rd_o) bank_val = bank_mem.exists(key(row, column)) ? bank_mem[key(row, column)] : 4'h0;
   end

   int tests = 0;
   int fails = 0;

   // Reference model state. Commands are scheduled as absolute cycle timestamps.
   int          n;
   int          free_at;
   bit          pend_m, open_m, m_accepted;
   logic [16:0] open_row_m, last_row;
   logic [9:0]  last_col;
   logic [5:0]  exp_vec [int];
   logic [3:0]  exp_dq  [int];
   logic [3:0]  exp_rd  [int];
   logic [3:0]  ref_mem [int];
   int          ref_obs;

   logic [5:0]  obs_vec;
   logic        obs_ready;
   logic [3:0]  obs_rdata;
   logic [16:0] obs_row;
   logic [9:0]  obs_col;

   typedef struct {
      bit          we;
      logic [16:0] row;
      logic [9:0]  col;
      logic [3:0]  wdata;
      logic [5:0]  first;
      int          acc_off;
      int          ready_off;
      logic [3:0]  rdata;
   } vec_t;

   vec_t table_v [8];

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, n, got, want);
      end
   endtask

   task automatic put(input int c, input logic [5:0] v);
      if (exp_vec.exists(c)) exp_vec[c] = exp_vec[c] | v;
      else exp_vec[c] = v;
   endtask

   task automatic model_reset();
      n = 0; free_at = 0; pend_m = 0; open_m = 0; m_accepted = 0;
      open_row_m = '0; last_row = '0; last_col = '0;
      exp_vec.delete(); exp_dq.delete(); exp_rd.delete();
   endtask

   task automatic reset_dut();
      req_valid = 1'b0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
   endtask

   // One clock cycle: compare the DUT with the model at the negedge, then advance the model.
   task automatic tick();
      logic [5:0]  ev;
      logic [16:0] er;
      logic [9:0]  ec;
      bit          idle;
      int          a, r, kk;
      @(negedge clk);
      if (n > 0 && n % TREFI == 0) pend_m = 1;
      idle = (n >= free_at);
      obs_vec   = {act_o, pr_o, rd_o, wr_o, ref_o, rdata_valid};
      obs_ready = req_ready;
      obs_rdata = rdata;
      obs_row   = row;
      obs_col   = column;
      ev = exp_vec.exists(n) ? exp_vec[n] : 6'b0;
      er = idle ? 17'd0 : last_row;
      ec = idle ? 10'd0 : last_col;
      check_output("strobes", {26'b0, obs_vec}, {26'b0, ev});
      check_output("one_strobe", {31'b0, $countones(obs_vec[5:1]) <= 1}, 32'd1);
      check_output("req_ready", {31'b0, obs_ready}, {31'b0, idle && !pend_m});
      check_output("address", {5'b0, obs_row, obs_col}, {5'b0, er, ec});
      if (ev[2]) begin
         check_output("wr_dq", {28'b0, dq}, {28'b0, exp_dq[n]});
         check_output("wr_dqs", {30'b0, dqs_t, dqs_c}, 32'd2);
      end else begin
         check_output("dqs_released", {31'b0, dqs_t === 1'b1}, 32'd0);
      end
      if (ev[0]) check_output("rdata", {28'b0, obs_rdata}, {28'b0, exp_rd[n]});
      if (obs_vec[1]) ref_obs++;
      m_accepted = 0;
      if (idle) begin
         if (pend_m) begin
            r = n + 1;
            if (open_m) begin
               put(r, V_PR);
               r += TRP;
            end
            put(r, V_REF);
            free_at = r + TRFC;
            open_m = 0;
            pend_m = 0;
         end else if (req_valid) begin
            m_accepted = 1;
            last_row = req_row;
            last_col = req_col;
            a = n + 1;
            if (!(open_m && open_row_m == req_row)) begin
               if (open_m) begin
                  put(a, V_PR);
                  a += TRP;
               end
               put(a, V_ACT);
               a += TRCD;
               open_m = 1;
               open_row_m = req_row;
            end
            kk = key(req_row, req_col);
            if (req_we) begin
               put(a, V_WR);
               exp_dq[a] = req_wdata;
               free_at = a + TWR;
               ref_mem[kk] = req_wdata;
            end else begin
               for (int k = 0; k < TCL; k++) put(a + k, V_RD);
               put(a + TCL, V_RV);
               exp_rd[a + TCL] = ref_mem.exists(kk) ? ref_mem[kk] : 4'h0;
               free_at = a + TCL;
            end
         end
      end
      @(posedge clk);
      #1;
      n++;
   endtask

   // Apply one table vector and measure command offsets relative to the accept edge.
   task automatic apply_stimulus(input vec_t v);
      int          waited, first_off, acc_off, ready_off, rv_off;
      logic [5:0]  first_cmd;
      logic [3:0]  got_rd;
      logic [16:0] acc_row;
      logic [9:0]  acc_col;
      req_we = v.we; req_row = v.row; req_col = v.col; req_wdata = v.wdata;
      req_valid = 1'b1;
      waited = 0;
      do begin
         tick();
         waited++;
      end while (!m_accepted && waited < 100);
      req_valid = 1'b0;
      first_off = -1; acc_off = -1; ready_off = -1; rv_off = -1;
      first_cmd = '0; got_rd = '0; acc_row = '0; acc_col = '0;
      for (int off = 1; off <= 40 && ready_off < 0; off++) begin
         tick();
         if (first_off < 0 && obs_vec[5:2] != 4'b0) begin
            first_off = off;
            first_cmd = obs_vec & 6'b111100;
         end
         if (acc_off < 0 && (obs_vec[3] || obs_vec[2])) begin
            acc_off = off;
            acc_row = obs_row;
            acc_col = obs_col;
         end
         if (obs_vec[0]) begin
            rv_off = off;
            got_rd = obs_rdata;
         end
         if (obs_ready) ready_off = off;
      end
      check_output("vec_first_cmd", {26'b0, first_cmd}, {26'b0, v.first});
      check_output("vec_access_cycle", acc_off, v.acc_off);
      check_output("vec_ready_cycle", ready_off, v.ready_off);
      check_output("vec_access_addr", {5'b0, acc_row, acc_col}, {5'b0, v.row, v.col});
      if (!v.we) begin
         check_output("vec_rdata_cycle", rv_off, v.ready_off);
         check_output("vec_rdata", {28'b0, got_rd}, {28'b0, v.rdata});
      end
   endtask

   task automatic new_request();
      req_we    = 1'($urandom_range(0, 1));
      req_row   = 17'($urandom_range(0, 3));
      req_col   = 10'($urandom_range(0, 3));
      req_wdata = 4'($urandom);
   endtask

   // Random traffic. A request is held until it is accepted and then replaced at once.
   task automatic run_random(input int cycles, input bit always_valid);
      for (int i = 0; i < cycles; i++) begin
         if (!req_valid && (always_valid || $urandom_range(0, 1) == 1)) begin
            new_request();
            req_valid = 1'b1;
         end
         tick();
         if (m_accepted) req_valid = 1'b0;
      end
      req_valid = 1'b0;
   endtask

   // Test sequence: reset values, table vectors, mid-wait reset, then randomized traffic.
   initial begin
      table_v[0] = '{1'b1, 17'd5, 10'd7, 4'hA, V_ACT, 4, 6, 4'h0};
      table_v[1] = '{1'b0, 17'd5, 10'd7, 4'h0, V_RD,  1, 3, 4'hA};
      table_v[2] = '{1'b1, 17'd9, 10'd7, 4'h3, V_PR,  7, 9, 4'h0};
      table_v[3] = '{1'b0, 17'd5, 10'd7, 4'h0, V_PR,  7, 9, 4'hA};
      table_v[4] = '{1'b0, 17'd9, 10'd7, 4'h0, V_PR,  7, 9, 4'h3};
      table_v[5] = '{1'b1, 17'd9, 10'd0, 4'hF, V_WR,  1, 3, 4'h0};
      table_v[6] = '{1'b0, 17'd9, 10'd0, 4'h0, V_RD,  1, 3, 4'hF};
      table_v[7] = '{1'b0, 17'd9, 10'd1, 4'h0, V_RD,  1, 3, 4'h0};
      model_reset();

      #1 rst = 1'b0;
      #2;
      check_output("reset_ready", {31'b0, req_ready}, 32'd1);
      check_output("reset_strobes", {26'b0, act_o, pr_o, rd_o, wr_o, ref_o, rdata_valid}, 32'd0);
      check_output("reset_rdata", {28'b0, rdata}, 32'd0);
      check_output("reset_addr", {5'b0, row, column}, 32'd0);
      reset_dut();

      foreach (table_v[i]) apply_stimulus(table_v[i]);

      reset_dut();
      req_we = 1'b1; req_row = 17'd3; req_col = 10'd1; req_wdata = 4'h5;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      check_output("busy_in_trcd", {31'b0, req_ready}, 32'd0);
      #2 rst = 1'b0;
      #1;
      check_output("async_reset_strobes", {27'b0, act_o, pr_o, rd_o, wr_o, ref_o}, 32'd0);
      check_output("async_reset_ready", {31'b0, req_ready}, 32'd1);
      check_output("async_reset_addr", {5'b0, row, column}, 32'd0);
      check_output("async_reset_dqs", {31'b0, dqs_t === 1'b1}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      repeat (3) tick();
      apply_stimulus('{1'b1, 17'd3, 10'd1, 4'h5, V_ACT, 4, 6, 4'h0});

      reset_dut();
      ref_obs = 0;
      run_random(460, 1'b1);
      check_output("refresh_count", ref_obs, 32'd2);

      run_random(500, 1'b0);
      repeat (20) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ddr_bank_initiator.md
# ddr_bank_initiator

Controller-side command initiator for one emulated DRAM bank. It accepts single-beat read/write requests on a valid/ready interface and sequences PR/ACT/RD/WR/REF strobes with parameterised tRP/tRCD/tCL/tWR/tRFC spacing. It drives the bank's shared `dq`/`dqs_t`/`dqs_c` pins during writes, samples `dq` during reads, tracks the open row, and inserts periodic refresh. It sits between the host/trace port and the bank emulation.

## Interface
- `WIDTH`, 4: dq width.
- `ROWS`, 131072: rows per bank; row field is `$clog2(ROWS)` bits.
- `COLS`, 1024: columns per bank; column field is `$clog2(COLS)` bits.
- `TRP`, 3: cycles from PR to next command.
- `TRCD`, 3: cycles from ACT to RD/WR.
- `TCL`, 2: cycles RD is held; `dq` is sampled in the last one.
- `TWR`, 2: cycles from WR until ready.
- `TRFC`, 8: cycles from REF until ready.
- `TREFI`, 200: refresh interval in cycles.
- All timing parameters are ≥1 and ≤255; counters are 8 bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_row` in `$clog2(ROWS)`: target row.
- `req_col` in `$clog2(COLS)`: target column.
- `req_wdata` in WIDTH: write data.
- `rdata` out WIDTH: read data.
- `rdata_valid` out 1: one-cycle pulse.
- `ACT`, `PR`, `RD`, `WR`, `REF` out 1 each: command strobes, mutually exclusive.
- `row` out `$clog2(ROWS)`; `column` out `$clog2(COLS)`: command address.
- `dq` inout WIDTH; `dqs_t`, `dqs_c` inout 1: bank data bus.

## Operation
- Registered state: the FSM state, the latched request, `open_valid`, `open_row`, an 8-bit wait counter, a free-running refresh counter, and `ref_pending`.
- States: IDLE, PRE, ACT_S, WR_S, RD_S, WAIT, REF_S.
  - WAIT counts down, then goes to the stored next state.
- `req_ready = (state==IDLE) && !ref_pending`. It is combinational.
- On accept, latch we/row/col/wdata, then:
  - hit (`open_valid && open_row==req_row`): go to WR_S or RD_S.
  - closed (`!open_valid`): go to ACT_S.
  - miss (open, different row): go to PRE.
- PRE: assert PR for 1 cycle, clear `open_valid`, wait TRP, then ACT_S.
- ACT_S: assert ACT for 1 cycle with `row`=latched row, set `open_valid`/`open_row`, wait TRCD, then the access state.
- WR_S: assert WR for 1 cycle.
  - Same cycle: drive `dq`=latched wdata, `dqs_t`=1, `dqs_c`=0.
  - Then wait TWR and return to IDLE.
  - `dq`/`dqs_*` are Z in every other cycle.
- RD_S: assert RD for TCL consecutive cycles with `row`/`column` stable and `dq` released.
  - Capture `dq` into `rdata` at the end of the last RD cycle.
  - Pulse `rdata_valid` in the next cycle and return to IDLE.
- Address outputs hold the latched request in every non-IDLE state and 0 in IDLE.
- Refresh: the refresh counter counts 0..TREFI-1 and wraps.
  - At the wrap, `ref_pending` is set. It stays set if already set, so there is no double refresh.
  - An in-flight access always completes first.
  - In IDLE with `ref_pending`: if a row is open, do PRE (PR, TRP) first; then REF_S.
  - REF_S asserts REF for 1 cycle, clears `ref_pending`, waits TRFC, then returns to IDLE.
  - A pending refresh takes priority over `req_valid` in the same cycle.
- Row policy: open-page. A row stays open until a miss or a refresh.

## Timing
- Reset values:
  - state IDLE, all strobes 0, `row`/`column` 0.
  - `dq`/`dqs_t`/`dqs_c` Z.
  - `rdata` 0, `rdata_valid` 0.
  - `open_valid` 0, refresh counter 0, `ref_pending` 0, `req_ready` 1.
- Reset asserted mid-sequence aborts immediately to the reset values. No PR is issued; the bank is re-initialised by its own reset.
- Latencies, measured from the accept edge (cycle 0):
  - hit write: WR at 1, ready at 1+TWR.
  - hit read: RD at 1..TCL, `rdata_valid` at TCL+1, ready at TCL+1.
  - closed write: ACT at 1, WR at 1+TRCD.
  - miss write: PR at 1, ACT at 1+TRP, WR at 1+TRP+TRCD.
- Back-to-back requests are accepted in the first cycle `req_ready` is high again; there is no bubble beyond that.

## Test plan
- Defaults, reset release, write row 5 col 7 data 0xA on a closed bank → ACT at cycle 1 with row=5, WR at cycle 4 with `dq`=0xA and `dqs_t`=1, `req_ready` high at cycle 6.
- Read row 5 col 7 immediately after, bank model returns 0xA → RD high cycles 1–2, no ACT, `rdata`=0xA with `rdata_valid` at cycle 3.
- Write row 9 while row 5 is open → PR at 1, ACT row 9 at 4, WR at 7; a following read of row 5 col 7 reopens row 5 and returns 0xA.
- Hold `req_valid` continuously across the 200-cycle boundary → the current access finishes, then PR (if open) and REF are issued, `req_ready` stays low through TRFC=8, the next access issues ACT (row closed), and exactly one REF is issued per 200 cycles.
- Assert `rst` during the TRCD wait → all strobes 0 and `dq` Z asynchronously; after release `req_ready`=1 and the next request starts with ACT.
- Check every cycle: at most one strobe high, and `dq` is driven only in WR cycles.
